// File: rtl/model_nexys_hls4ml_prj_1_dense_acc_out_if.sv
// Handshake bundle between the dense-layer multiplier, the accumulate/output stage and the next layer.
// slave is the accumulate stage's view; master is the view of whatever feeds products and consumes results.
interface model_nexys_hls4ml_prj_1_dense_acc_out_if #(
   parameter int PROD_WIDTH = 23,
   parameter int BIAS_WIDTH = 16,
   parameter int OUT_WIDTH  = 16
);
   logic                         in_valid;
   logic                         in_ready;
   logic signed [PROD_WIDTH-1:0] in_prod;
   logic                         in_last;
   logic signed [BIAS_WIDTH-1:0] bias;
   logic                         out_valid;
   logic                         out_ready;
   logic signed [OUT_WIDTH-1:0]  out_data;
   logic                         out_sat;

   modport slave (
      input  in_valid, in_prod, in_last, bias, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );

   modport master (
      output in_valid, in_prod, in_last, bias, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );
endinterface

// File: rtl/model_nexys_hls4ml_prj_1_dense_acc_out.sv
// Dense-layer accumulator: sums N_TERMS products onto a bias, then rounds, shifts, saturates,
// optionally ReLU-clamps, and hands the result on through a two-stage valid/ready pipeline.
module model_nexys_hls4ml_prj_1_dense_acc_out #(
   parameter int PROD_WIDTH = 23,
   parameter int BIAS_WIDTH = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int N_TERMS    = 16,
   parameter int FRAC_SHIFT = 10,
   parameter int OUT_WIDTH  = 16,
   parameter int RELU       = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic ce,
   model_nexys_hls4ml_prj_1_dense_acc_out_if.slave io,
   output logic err_last
);
   localparam int CNT_W = $clog2(N_TERMS);
   localparam int RW    = ACC_WIDTH + 1;
   localparam logic [CNT_W-1:0]     LAST_CNT   = CNT_W'(N_TERMS - 1);
   localparam logic signed [RW-1:0] ROUND_HALF = RW'(2 ** (FRAC_SHIFT - 1));
   localparam logic signed [RW-1:0] OUT_MAX    = RW'(2 ** (OUT_WIDTH - 1) - 1);
   localparam logic signed [RW-1:0] OUT_MIN    = RW'(-(2 ** (OUT_WIDTH - 1)));

   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
   logic                        sum_v_q, sum_v_d;
   logic                        out_valid_q, out_valid_d;
   logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic                        out_sat_q, out_sat_d;
   logic                        err_last_q, err_last_d;

   logic                        stall, accept, advance, drain, is_last;
   logic signed [ACC_WIDTH-1:0] prod_ext, bias_ext;
   logic signed [RW-1:0]        rounded, shifted;
   logic signed [OUT_WIDTH-1:0] res_data;
   logic                        res_sat;

   assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){io.in_prod[PROD_WIDTH-1]}}, io.in_prod};
   assign bias_ext = {{(ACC_WIDTH - BIAS_WIDTH){io.bias[BIAS_WIDTH-1]}}, io.bias};

   // Widened by one bit so the rounding constant can never wrap a large positive sum.
   always_comb begin
      rounded  = $signed({sum_q[ACC_WIDTH-1], sum_q}) + ROUND_HALF;
      shifted  = rounded >>> FRAC_SHIFT;
      res_sat  = 1'b0;
      res_data = shifted[OUT_WIDTH-1:0];
      if (shifted > OUT_MAX) begin
         res_data = OUT_MAX[OUT_WIDTH-1:0];
         res_sat  = 1'b1;
      end else if (shifted < OUT_MIN) begin
         res_data = OUT_MIN[OUT_WIDTH-1:0];
         res_sat  = 1'b1;
      end
      if (RELU != 0 && res_data[OUT_WIDTH-1]) res_data = '0;
   end

   always_comb begin
      stall   = sum_v_q & out_valid_q & ~io.out_ready;
      accept  = ce & io.in_valid & ~stall;
      advance = ce & sum_v_q & (~out_valid_q | io.out_ready);
      drain   = ce & out_valid_q & io.out_ready & ~advance;
      is_last = (cnt_q == LAST_CNT);

      cnt_d       = cnt_q;
      acc_d       = acc_q;
      sum_d       = sum_q;
      sum_v_d     = sum_v_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      err_last_d  = err_last_q;

      if (advance) begin
         out_data_d  = res_data;
         out_sat_d   = res_sat;
         out_valid_d = 1'b1;
         sum_v_d     = 1'b0;
      end else if (drain) begin
         out_valid_d = 1'b0;
      end

      // NOTE: the final-term update comes after the advance so that, when both happen in one
      // cycle, the later assignment wins and sum_v stays set for the newly finished sum.
      if (accept) begin
         cnt_d = is_last ? '0 : cnt_q + 1'b1;
         if (io.in_last != is_last) err_last_d = 1'b1;
         if (cnt_q == '0)  acc_d = bias_ext + prod_ext;
         else              acc_d = acc_q + prod_ext;
         if (is_last) begin
            sum_d   = acc_q + prod_ext;
            sum_v_d = 1'b1;
         end
      end
   end

   // NOTE: ce is folded into accept/advance/drain, so every _d equals its _q while ce is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         sum_q       <= '0;
         sum_v_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         err_last_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         sum_q       <= sum_d;
         sum_v_q     <= sum_v_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         err_last_q  <= err_last_d;
      end
   end

   assign io.in_ready  = ~stall;
   assign io.out_valid = out_valid_q;
   assign io.out_data  = out_data_q;
   assign io.out_sat   = out_sat_q;
   assign err_last     = err_last_q;
endmodule

// File: tb/tb_model_nexys_hls4ml_prj_1_dense_acc_out.sv
// Directed bench: five parameterisations share one stimulus bus; sel routes beats to one of them
// and muxes its outputs back for checking.
module tb_model_nexys_hls4ml_prj_1_dense_acc_out;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ce = 1'b1;
   logic drv_valid = 1'b0;
   logic signed [22:0] drv_prod = '0;
   logic drv_last = 1'b0;
   logic signed [15:0] drv_bias = '0;
   logic drv_out_ready = 1'b1;
   int sel = 0;
   int cyc = 0;
   int checks = 0;
   int errors = 0;

   logic obs_in_ready, obs_out_valid, obs_out_sat, obs_err_last;
   logic signed [15:0] obs_out_data;
   logic [4:0] err_v;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 0: defaults (N16 ReLU)  1: N4 ReLU  2: N2 no ReLU  3: N2 ReLU  4: N16 no ReLU
   model_nexys_hls4ml_prj_1_dense_acc_out_if if_v[5] ();

   model_nexys_hls4ml_prj_1_dense_acc_out dut_a (
      .clk(clk), .reset(reset), .ce(ce), .io(if_v[0].slave), .err_last(err_v[0]));
   model_nexys_hls4ml_prj_1_dense_acc_out #(.N_TERMS(4)) dut_b (
      .clk(clk), .reset(reset), .ce(ce), .io(if_v[1].slave), .err_last(err_v[1]));
   model_nexys_hls4ml_prj_1_dense_acc_out #(.N_TERMS(2), .RELU(0)) dut_c (
      .clk(clk), .reset(reset), .ce(ce), .io(if_v[2].slave), .err_last(err_v[2]));
   model_nexys_hls4ml_prj_1_dense_acc_out #(.N_TERMS(2), .RELU(1)) dut_d (
      .clk(clk), .reset(reset), .ce(ce), .io(if_v[3].slave), .err_last(err_v[3]));
   model_nexys_hls4ml_prj_1_dense_acc_out #(.RELU(0)) dut_e (
      .clk(clk), .reset(reset), .ce(ce), .io(if_v[4].slave), .err_last(err_v[4]));

   logic [4:0] rdy_v, val_v, sat_v;
   logic signed [15:0] dat_v [5];

   for (genvar k = 0; k < 5; k++) begin : g_bus
      assign if_v[k].in_valid  = drv_valid && (sel == k);
      assign if_v[k].in_prod   = drv_prod;
      assign if_v[k].in_last   = drv_last;
      assign if_v[k].bias      = drv_bias;
      assign if_v[k].out_ready = drv_out_ready;
      assign rdy_v[k] = if_v[k].in_ready;
      assign val_v[k] = if_v[k].out_valid;
      assign sat_v[k] = if_v[k].out_sat;
      assign dat_v[k] = if_v[k].out_data;
   end

   always_comb begin
      obs_in_ready  = rdy_v[sel];
      obs_out_valid = val_v[sel];
      obs_out_sat   = sat_v[sel];
      obs_out_data  = dat_v[sel];
      obs_err_last  = err_v[sel];
   end

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      drv_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Presents one beat and waits (bounded) for the edge that accepts it.
   task automatic beat(input logic signed [22:0] p, input logic last);
      logic ok;
      ok = 1'b0;
      drv_valid = 1'b1;
      drv_prod  = p;
      drv_last  = last;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         ok = obs_in_ready && ce;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      check("beat_accepted", ok, 1);
      drv_valid = 1'b0;
   endtask

   task automatic neuron(input logic signed [15:0] b, input logic signed [22:0] p, input int n);
      drv_bias = b;
      for (int i = 0; i < n; i++) beat(p, i == n - 1);
   endtask

   task automatic wait_out(input string tag, input logic signed [15:0] d, input logic s);
      for (int i = 0; i < 100; i++) begin
         if (obs_out_valid) break;
         @(posedge clk);
         #1;
      end
      check({tag, "_valid"}, obs_out_valid, 1);
      check({tag, "_data"}, obs_out_data, d);
      check({tag, "_sat"}, obs_out_sat, s);
   endtask

   initial begin
      int t0;
      do_reset();
      check("rst_in_ready", obs_in_ready, 1);
      check("rst_out_valid", obs_out_valid, 0);
      check("rst_out_data", obs_out_data, 0);
      check("rst_out_sat", obs_out_sat, 0);
      check("rst_err_last", obs_err_last, 0);

      // Basic N=4 neuron and one-cycle output latency
      sel = 1;
      neuron(16'sd0, 23'sd1024, 4);
      check("n4_valid_early", obs_out_valid, 0);
      @(posedge clk); #1;
      check("n4_valid", obs_out_valid, 1);
      check("n4_data", obs_out_data, 4);
      check("n4_sat", obs_out_sat, 0);
      check("n4_err_last", obs_err_last, 0);

      // Rounding half up
      sel = 2;
      drv_bias = 16'sd0;
      beat(23'sd1024, 1'b0); beat(23'sd512, 1'b1);
      wait_out("round_pos", 16'sd2, 1'b0);
      beat(-23'sd1024, 1'b0); beat(-23'sd512, 1'b1);
      wait_out("round_neg", -16'sd1, 1'b0);
      sel = 3;
      beat(-23'sd1024, 1'b0); beat(-23'sd512, 1'b1);
      wait_out("round_relu", 16'sd0, 1'b0);

      // Saturation at both bounds
      sel = 0;
      neuron(16'sd32767, 23'sd4194303, 16);
      wait_out("sat_hi", 16'sd32767, 1'b1);
      sel = 4;
      neuron(16'sd0, -23'sd4194304, 16);
      wait_out("sat_lo", -16'sd32768, 1'b1);

      // Backpressure: two neurons pile up behind a stalled consumer
      sel = 1;
      drv_out_ready = 1'b0;
      neuron(16'sd0, 23'sd1024, 4);
      neuron(16'sd0, 23'sd2048, 4);
      check("bp_in_ready_low", obs_in_ready, 0);
      check("bp_first_data", obs_out_data, 4);
      repeat (3) @(posedge clk);
      #1;
      check("bp_held_valid", obs_out_valid, 1);
      check("bp_held_data", obs_out_data, 4);
      check("bp_still_stalled", obs_in_ready, 0);
      drv_out_ready = 1'b1;
      #1;
      check("bp_ready_release", obs_in_ready, 1);
      @(posedge clk); #1;
      check("bp_second_valid", obs_out_valid, 1);
      check("bp_second_data", obs_out_data, 8);
      @(posedge clk); #1;
      check("bp_drained", obs_out_valid, 0);
      neuron(16'sd0, 23'sd1024, 4);
      wait_out("bp_after", 16'sd4, 1'b0);

      // Early in_last sets the sticky error without disturbing the sum
      sel = 0;
      drv_bias = 16'sd0;
      beat(23'sd1024, 1'b0);
      check("el_before", obs_err_last, 0);
      beat(23'sd1024, 1'b1);
      check("el_set", obs_err_last, 1);
      for (int i = 2; i < 16; i++) beat(23'sd1024, i == 15);
      wait_out("el_sum", 16'sd16, 1'b0);
      check("el_sticky", obs_err_last, 1);

      // Reset mid-neuron discards the partial sum
      drv_bias = 16'sd100;
      for (int i = 0; i < 7; i++) beat(23'sd5000, 1'b0);
      do_reset();
      check("mid_rst_err_last", obs_err_last, 0);
      check("mid_rst_out_valid", obs_out_valid, 0);
      t0 = cyc;
      neuron(16'sd0, 23'sd1024, 16);
      wait_out("post_rst", 16'sd16, 1'b0);
      check("post_rst_latency", cyc - t0, 17);

      // Three ce-low cycles mid-vector delay the result by three cycles
      @(posedge clk); #1;
      drv_bias = 16'sd0;
      t0 = cyc;
      for (int i = 0; i < 8; i++) beat(23'sd1024, 1'b0);
      ce = 1'b0;
      drv_valid = 1'b1;
      drv_prod = 23'sd1024;
      drv_last = 1'b0;
      repeat (3) @(posedge clk);
      #1 ce = 1'b1;
      for (int i = 8; i < 16; i++) beat(23'sd1024, i == 15);
      wait_out("ce_gap", 16'sd16, 1'b0);
      check("ce_gap_latency", cyc - t0, 20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
